pipe_array_mult: RTL

//  Parametrised, pipelined unsigned array multiplier built from rows of
//  AND-gated partial-product half/full-adder carry cells.

---
 rtl/pipe_array_mult_if.sv | 33 +++
 rtl/pipe_array_mult.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_array_mult_if.sv
// pipe_array_mult_if: operand/result handshake bundle for pipe_array_mult.
//   in_valid/in_ready/in_x/in_y : operand side (in_signed too when SIGNED_EN is defined)
//   out_valid/out_ready/out_p   : product side
//   busy                        : any pipeline stage holds a valid token
//   master = operand issuer / result consumer, slave = the multiplier.
// Optional feature macro: SIGNED_EN.
interface pipe_array_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
`ifdef SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

`ifdef SIGNED_EN
  modport master (output in_valid, in_x, in_y, in_signed, out_ready,
                  input  in_ready, out_valid, out_p, busy);
  modport slave  (input  in_valid, in_x, in_y, in_signed, out_ready,
                  output in_ready, out_valid, out_p, busy);
`else
  modport master (output in_valid, in_x, in_y, out_ready,
                  input  in_ready, out_valid, out_p, busy);
  modport slave  (input  in_valid, in_x, in_y, out_ready,
                  output in_ready, out_valid, out_p, busy);
`endif
endinterface

// File: rtl/pipe_array_mult.sv
// pipe_array_mult: pipelined array multiplier. Each stage folds ROWS_PER_STAGE
// AND-gated partial-product rows into a carry-save (sum, carry) pair; the last
// stage also does the carry-propagate add, so latency is NSTAGE edges.
// Ports: clk, rst_n (async, active-low), bus (pipe_array_mult_if.slave):
//   in_valid/in_ready/in_x/in_y in, out_valid/out_ready/out_p out, busy.
// Optional: SIGNED_EN adds bus.in_signed, selecting a Baugh-Wooley signed
// product per token. Undefined -> unsigned only, same latency.
module pipe_array_mult #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ROWS_PER_STAGE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_array_mult_if.slave  bus
);
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned NSTAGE = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1)
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic              adv;
  logic              in_sgn;
  logic [NSTAGE-1:0] vld_q;
  logic [NSTAGE-1:0] sgn_q;
  logic [WIDTH-1:0]  x_q   [NSTAGE];
  logic [WIDTH-1:0]  y_q   [NSTAGE];
  logic [PW-1:0]     sum_q [NSTAGE];
  logic [PW-1:0]     car_q [NSTAGE];

  // stage inputs: index 0 is the operand port, index k is register k-1
  logic [NSTAGE-1:0] vld_c;
  logic [NSTAGE-1:0] sgn_c;
  logic [WIDTH-1:0]  x_c   [NSTAGE];
  logic [WIDTH-1:0]  y_c   [NSTAGE];
  logic [PW-1:0]     sum_c [NSTAGE];
  logic [PW-1:0]     car_c [NSTAGE];
  logic [PW-1:0]     sum_d [NSTAGE];
  logic [PW-1:0]     car_d [NSTAGE];
  logic [PW:0]       fin;

`ifdef SIGNED_EN
  assign in_sgn = bus.in_signed;
`else
  assign in_sgn = 1'b0;
`endif

  // Global stall: everything holds while the output token is refused
  assign adv           = !(vld_q[NSTAGE-1] && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NSTAGE-1];
  assign bus.out_p     = sum_q[NSTAGE-1];
  assign bus.busy      = |vld_q;

  // One partial-product row y[i]&x at weight 2^i; signed tokens invert the
  // terms where exactly one operand bit is the MSB.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x,
                                           input logic yb, input int i,
                                           input logic sgn);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      b[j] = x[j] & yb;
      if (sgn && ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)))
        b[j] = ~b[j];
    end
    return PW'(b) << i;
  endfunction

  // Stage input selection
  always_comb begin
    vld_c[0] = bus.in_valid;
    sgn_c[0] = in_sgn;
    x_c[0]   = bus.in_x;
    y_c[0]   = bus.in_y;
    sum_c[0] = in_sgn ? BW_CORR : '0;
    car_c[0] = '0;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      vld_c[k] = vld_q[k-1];
      sgn_c[k] = sgn_q[k-1];
      x_c[k]   = x_q[k-1];
      y_c[k]   = y_q[k-1];
      sum_c[k] = sum_q[k-1];
      car_c[k] = car_q[k-1];
    end
  end

  // Carry-save row reduction per stage, then the final carry-propagate add
  always_comb begin
    logic [PW-1:0] a;
    logic [PW-1:0] c;
    logic [PW-1:0] pp;
    logic [PW-1:0] t;
    a  = '0;
    c  = '0;
    pp = '0;
    t  = '0;
    for (int s = 0; s < int'(NSTAGE); s++) begin
      a = sum_c[s];
      c = car_c[s];
      for (int r = 0; r < int'(ROWS_PER_STAGE); r++) begin
        if (s * int'(ROWS_PER_STAGE) + r < int'(WIDTH)) begin
          pp = pp_row(x_c[s], y_c[s][s * int'(ROWS_PER_STAGE) + r],
                      s * int'(ROWS_PER_STAGE) + r, sgn_c[s]);
          t  = a ^ c ^ pp;
          c  = ((a & c) | (a & pp) | (c & pp)) << 1;
          a  = t;
        end
      end
      sum_d[s] = a;
      car_d[s] = c;
    end
    fin = {1'b0, sum_d[NSTAGE-1]} + {1'b0, car_d[NSTAGE-1]};
  end

  // Stage registers; data loads only with a valid token so out_p holds on bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sgn_q <= '0;
      for (int s = 0; s < int'(NSTAGE); s++) begin
        x_q[s]   <= '0;
        y_q[s]   <= '0;
        sum_q[s] <= '0;
        car_q[s] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < int'(NSTAGE); s++) begin
        vld_q[s] <= vld_c[s];
        if (vld_c[s]) begin
          sgn_q[s] <= sgn_c[s];
          x_q[s]   <= x_c[s];
          y_q[s]   <= y_c[s];
          if (s == int'(NSTAGE) - 1) begin
            sum_q[s] <= fin[PW-1:0];
            car_q[s] <= '0;
          end else begin
            sum_q[s] <= sum_d[s];
            car_q[s] <= car_d[s];
          end
        end
      end
    end
  end

  // Unsigned products fit exactly; signed ones wrap modulo 2^PW by design
  a_no_carry_out: assert property (@(posedge clk) disable iff (!rst_n)
    (adv && vld_c[NSTAGE-1] && !sgn_c[NSTAGE-1]) |-> !fin[PW]);

endmodule
